ps2_keyboard_decoder: RTL
=========================

// Module: ps2_keyboard_decoder
//
// PURPOSE
// - Receiving end of the PS/2 keyboard link; produces the kstb/make/code event stream consumed by the keyboard matrix block.
// - Deserialises device-to-host PS/2 frames (scan code set 2) and strips the E0 (extended) and F0 (break) prefixes.
// - Emits one strobe per complete key event, in the system clock domain (56 MHz).
//
// PARAMETERS
// - FILTER   8       clock cycles a synchronised PS/2 line must hold a new level before the filtered copy follows it.
// - TIMEOUT  112000  clock cycles (2 ms at 56 MHz) without a filtered ps2ck falling edge mid-frame before the frame is aborted.
//
// PORTS
// - clock  in   1  system clock, 56 MHz; all logic on posedge.
// - reset  in   1  asynchronous, active-low reset.
// - ps2ck  in   1  PS/2 clock line, asynchronous to clock.
// - ps2dt  in   1  PS/2 data line, asynchronous to clock.
// - kstb   out  1  one-cycle strobe; make, ext and code are valid while it is high.
// - make   out  1  1 = key pressed, 0 = key released (F0 prefix seen).
// - ext    out  1  1 = E0 prefix preceded this code.
// - code   out  8  scan code byte, prefixes excluded.
// - perr   out  1  one-cycle strobe on a parity or stop-bit error.
//
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE, prefix flags cleared, counters cleared.
// - Input conditioning:
//   - Each line passes through a 2-FF synchroniser, then a FILTER-cycle glitch filter.
//   - A falling edge of the filtered ps2ck is the sample event. Filtered ps2dt is sampled on that edge.
// - FSM states IDLE, DATA, PARITY, STOP:
//   - IDLE: on a sample with data 0 (start bit), go to DATA with bit count 0. On a sample with data 1, stay in IDLE (spurious edge).
//   - DATA: shift in 8 bits, LSB first. After bit 7, go to PARITY.
//   - PARITY: store the bit and go to STOP.
//   - STOP: require stop=1 and odd parity over the 8 data bits plus the parity bit. Return to IDLE on either outcome.
// - Timeout: a counter reloads on every sample event. If it reaches TIMEOUT while not in IDLE, return to IDLE.
//   - Partial bits are dropped; prefix flags are kept; no strobe is issued.
// - Byte handling on a valid frame:
//   - E0: set ext_f; no strobe.
//   - F0: set brk_f; no strobe.
//   - Any other byte: kstb=1 on the clock after the stop-bit sample, with code=byte, make=!brk_f, ext=ext_f. Then clear both flags.
// - Invalid frame (parity or stop error): perr=1 for one cycle, byte discarded, both flags cleared.
// - Output holding: make, ext and code hold their last values between strobes. kstb and perr are never high together.
// - Latency: stop-bit sample edge detected at cycle N -> kstb or perr high at cycle N+1.
// - Filter latency: ps2ck pin to detected edge is 2+FILTER cycles.
// - Reset asserted mid-frame: immediate return to IDLE. The frame in progress is lost silently.
//
// CONFIGURATION
// - PS2_TYPEMATIC_FILTER_EN defined:
//   - The block remembers the last {ext, code} that produced a make event.
//   - A further make with the same {ext, code} and no intervening break of that key is suppressed (no kstb).
//   - A break of that key, or a make of a different key, re-arms the filter. Reset clears the memory.
// - PS2_TYPEMATIC_FILTER_EN undefined:
//   - Every make byte, including typematic repeats, produces a kstb.
//
// TESTING
// - Frame 0x1C (odd parity, stop=1) -> one kstb; make=1, ext=0, code=8'h1C; perr stays 0.
// - Frames F0,1C -> no strobe after F0; after 1C, one kstb with make=0, ext=0, code=8'h1C.
// - Frames E0,F0,75 -> exactly one kstb, with make=0, ext=1, code=8'h75. Then frame 75 -> kstb with make=1, ext=0 (flags cleared).
// - Frame 1C with a wrong parity bit -> perr one cycle, no kstb. Next good frame 0x22 -> kstb with code=8'h22.
// - Timeout and glitch filter:
//   - Start bit plus 4 data bits, then 2.5 ms idle -> back in IDLE, no strobe. Next full frame 0x1C decodes correctly.
//   - A 3-cycle glitch on ps2ck -> ignored.
// - Frames 1C,1C,1C -> one kstb with the macro defined, three without. F0,1C then 1C -> a make strobe occurs in both builds.

Source files
------------

// File: rtl/ps2_keyboard_decoder.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_decoder
//
// Purpose: receiving end of the PS/2 keyboard link (device-to-host frames,
// scan code set 2). The module conditions the asynchronous PS/2 lines and
// deserialises 11-bit frames. It strips the E0 (extended) and F0 (break)
// prefixes and emits one strobe per key event in the system clock domain.
//
// Ports:
//   clock  in   1  system clock (56 MHz), all logic on posedge
//   reset  in   1  asynchronous, active-low reset
//   ps2ck  in   1  PS/2 clock line (asynchronous)
//   ps2dt  in   1  PS/2 data line (asynchronous)
//   kstb   out  1  one-cycle key event strobe
//   make   out  1  1 = press, 0 = release; held between strobes
//   ext    out  1  1 = E0 prefix preceded the code; held between strobes
//   code   out  8  scan code byte without prefixes; held between strobes
//   perr   out  1  one-cycle strobe on a parity or stop-bit error
//
// Parameters:
//   FILTER   cycles a synchronised line must hold a new level before the
//            filtered copy follows it
//   TIMEOUT  cycles without a sample edge mid-frame before the frame is
//            aborted
//
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN
//   When it is defined, a repeated make of the last pressed key is
//   suppressed until that key is released or a different key is pressed.
// ---------------------------------------------------------------------------
module ps2_keyboard_decoder #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 112000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2ck,
    input  logic       ps2dt,
    output logic       kstb,
    output logic       make,
    output logic       ext,
    output logic [7:0] code,
    output logic       perr
);

    localparam int FLT_W  = $clog2(FILTER + 1);
    localparam int TOUT_W = $clog2(TIMEOUT + 1);
    localparam logic [FLT_W-1:0]  FLT_MAX = FLT_W'(FILTER - 1);
    localparam logic [TOUT_W-1:0] TO_MAX  = TOUT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity over data plus parity bit: frame is good when the XOR is 1.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Line conditioning: index 0 = ps2ck, index 1 = ps2dt
    logic [1:0]       meta_r;
    logic [1:0]       sync_r;
    logic [1:0]       filt_r;
    logic [FLT_W-1:0] fcnt_r [2];
    logic             ck_d_r;
    logic             fall_s;

    // Frame state
    state_t            state_r, state_s;
    logic [2:0]        bitcnt_r, bitcnt_s;
    logic [7:0]        shift_r, shift_s;
    logic              par_r, par_s;
    logic              ext_f_r, ext_f_s;
    logic              brk_f_r, brk_f_s;
    logic [TOUT_W-1:0] to_cnt_r;

    // Output registers
    logic       kstb_r, kstb_s;
    logic       perr_r, perr_s;
    logic       make_r, make_s;
    logic       ext_r, ext_s;
    logic [7:0] code_r, code_s;
    logic       emit_s;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_key_r, last_key_s;
    logic       last_vld_r, last_vld_s;
    logic       key_match_s;
`endif

    // Two-flop synchroniser followed by a per-line glitch filter.
    // Idle PS/2 lines are high, so the lines reset to 1 to avoid a false edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_r    <= 2'b11;
            sync_r    <= 2'b11;
            filt_r    <= 2'b11;
            fcnt_r[0] <= '0;
            fcnt_r[1] <= '0;
            ck_d_r    <= 1'b1;
        end else begin
            meta_r <= {ps2dt, ps2ck};
            sync_r <= meta_r;
            ck_d_r <= filt_r[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] != filt_r[i]) begin
                    if (fcnt_r[i] == FLT_MAX) begin
                        filt_r[i] <= sync_r[i];
                        fcnt_r[i] <= '0;
                    end else begin
                        fcnt_r[i] <= fcnt_r[i] + FLT_W'(1);
                    end
                end else begin
                    fcnt_r[i] <= '0;
                end
            end
        end
    end

    // Sample event: falling edge of the filtered clock line
    assign fall_s = ck_d_r & ~filt_r[0];

    // Mid-frame watchdog: cleared by every sample and whenever idle, saturates at TIMEOUT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= '0;
        end else if (fall_s || (state_r == IDLE)) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TOUT_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign key_match_s = last_vld_r && (last_key_r == {ext_f_r, shift_r});
`endif

    // Next-state, prefix tracking and output decode
    always_comb begin
        state_s  = state_r;
        bitcnt_s = bitcnt_r;
        shift_s  = shift_r;
        par_s    = par_r;
        ext_f_s  = ext_f_r;
        brk_f_s  = brk_f_r;
        kstb_s   = 1'b0;
        perr_s   = 1'b0;
        make_s   = make_r;
        ext_s    = ext_r;
        code_s   = code_r;
        emit_s   = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        last_key_s = last_key_r;
        last_vld_s = last_vld_r;
`endif
        if (fall_s) begin
            case (state_r)
                IDLE: begin
                    // A sample with data 1 here is a spurious edge and is ignored
                    if (!filt_r[1]) begin
                        state_s  = DATA;
                        bitcnt_s = 3'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    shift_s = {filt_r[1], shift_r[7:1]};
                    if (bitcnt_r == 3'd7) begin
                        state_s = PARITY;
                    end else begin
                        bitcnt_s = bitcnt_r + 3'd1;
                    end
                end
                PARITY: begin
                    par_s   = filt_r[1];
                    state_s = STOP;
                end
                STOP: begin
                    state_s = IDLE;
                    if (filt_r[1] && odd_parity_ok(shift_r, par_r)) begin
                        if (shift_r == 8'hE0) begin
                            ext_f_s = 1'b1;
                        end else if (shift_r == 8'hF0) begin
                            brk_f_s = 1'b1;
                        end else begin
                            ext_f_s = 1'b0;
                            brk_f_s = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                            if (!brk_f_r) begin
                                if (key_match_s) begin
                                    emit_s = 1'b0;
                                end else begin
                                    emit_s     = 1'b1;
                                    last_key_s = {ext_f_r, shift_r};
                                    last_vld_s = 1'b1;
                                end
                            end else begin
                                // Releasing the remembered key re-arms the filter
                                emit_s = 1'b1;
                                if (key_match_s) begin
                                    last_vld_s = 1'b0;
                                end else begin
                                    last_vld_s = last_vld_r;
                                end
                            end
`else
                            emit_s = 1'b1;
`endif
                            if (emit_s) begin
                                kstb_s = 1'b1;
                                code_s = shift_r;
                                make_s = ~brk_f_r;
                                ext_s  = ext_f_r;
                            end else begin
                                kstb_s = 1'b0;
                            end
                        end
                    end else begin
                        perr_s  = 1'b1;
                        ext_f_s = 1'b0;
                        brk_f_s = 1'b0;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else if ((state_r != IDLE) && (to_cnt_r == TO_MAX)) begin
            // Abandon the partial frame but keep any prefix already seen
            state_s = IDLE;
        end else begin
            state_s = state_r;
        end
    end

    // State, prefix and registered-output update
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            bitcnt_r <= 3'd0;
            shift_r  <= 8'h00;
            par_r    <= 1'b0;
            ext_f_r  <= 1'b0;
            brk_f_r  <= 1'b0;
            kstb_r   <= 1'b0;
            perr_r   <= 1'b0;
            make_r   <= 1'b0;
            ext_r    <= 1'b0;
            code_r   <= 8'h00;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_key_r <= 9'h000;
            last_vld_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            bitcnt_r <= bitcnt_s;
            shift_r  <= shift_s;
            par_r    <= par_s;
            ext_f_r  <= ext_f_s;
            brk_f_r  <= brk_f_s;
            kstb_r   <= kstb_s;
            perr_r   <= perr_s;
            make_r   <= make_s;
            ext_r    <= ext_s;
            code_r   <= code_s;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_key_r <= last_key_s;
            last_vld_r <= last_vld_s;
`endif
        end
    end

    assign kstb = kstb_r;
    assign perr = perr_r;
    assign make = make_r;
    assign ext  = ext_r;
    assign code = code_r;

endmodule
